// File: rtl/ex_reg.sv
// EX/MEM pipeline register: latches ALU result plus instruction context, raises overflow/misalign exceptions.
// Latency: one cycle from Id*/Alu* inputs to Ex* outputs; OfCount updates on the same edge.
// Backpressure: Stall freezes every register (Flush included); Flush alone loads a bubble.
module ex_reg #(
    parameter int         DATA_W      = 32,
    parameter int         PC_W        = 30,
    parameter int         CNT_W       = 16,
    parameter logic [3:0] ALU_OP_ADDS = 4'd4,
    parameter logic [3:0] ALU_OP_SUBS = 4'd5
) (
    input  logic              Clk,
    input  logic              Reset_,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [PC_W-1:0]   IdPc,
    input  logic              IdEn,
    input  logic [3:0]        IdAluOp,
    input  logic [1:0]        IdMemOp,
    input  logic [DATA_W-1:0] IdMemWrData,
    input  logic [4:0]        IdDstAddr,
    input  logic              IdGprWe,
    input  logic [2:0]        IdExpCode,
    input  logic [DATA_W-1:0] AluOut,
    input  logic              AluOF,
    output logic [PC_W-1:0]   ExPc,
    output logic              ExEn,
    output logic [1:0]        ExMemOp,
    output logic [DATA_W-1:0] ExMemWrData,
    output logic [4:0]        ExDstAddr,
    output logic              ExGprWe,
    output logic [2:0]        ExExpCode,
    output logic [DATA_W-1:0] ExOut,
    output logic [CNT_W-1:0]  OfCount
);

    localparam logic [2:0] NO_EXP         = 3'd0;
    localparam logic [2:0] EXP_OVERFLOW   = 3'd3;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [1:0] MEM_NOP        = 2'd0;

    logic [PC_W-1:0]   ex_pc_q,          ex_pc_d;
    logic              ex_en_q,          ex_en_d;
    logic [1:0]        ex_mem_op_q,      ex_mem_op_d;
    logic [DATA_W-1:0] ex_mem_wr_data_q, ex_mem_wr_data_d;
    logic [4:0]        ex_dst_addr_q,    ex_dst_addr_d;
    logic              ex_gpr_we_q,      ex_gpr_we_d;
    logic [2:0]        ex_exp_code_q,    ex_exp_code_d;
    logic [DATA_W-1:0] ex_out_q,         ex_out_d;
    logic [CNT_W-1:0]  of_count_q,       of_count_d;

    logic       ovf;
    logic       mis;
    logic [2:0] exp_code_nxt;

    // AluOF is only meaningful for the signed add/sub ops; it is stale otherwise.
    always_comb begin
        ovf = IdEn & AluOF & ((IdAluOp == ALU_OP_ADDS) | (IdAluOp == ALU_OP_SUBS));
        mis = IdEn & (IdMemOp != MEM_NOP) & (AluOut[1:0] != 2'b00);

        exp_code_nxt = NO_EXP;
        if (!IdEn)
            exp_code_nxt = NO_EXP;
        else if (IdExpCode != NO_EXP)
            exp_code_nxt = IdExpCode;
        else if (ovf)
            exp_code_nxt = EXP_OVERFLOW;
        else if (mis)
            exp_code_nxt = EXP_MISS_ALIGN;
    end

    always_comb begin
        ex_pc_d          = ex_pc_q;
        ex_en_d          = ex_en_q;
        ex_mem_op_d      = ex_mem_op_q;
        ex_mem_wr_data_d = ex_mem_wr_data_q;
        ex_dst_addr_d    = ex_dst_addr_q;
        ex_gpr_we_d      = ex_gpr_we_q;
        ex_exp_code_d    = ex_exp_code_q;
        ex_out_d         = ex_out_q;
        of_count_d       = of_count_q;

        if (!Stall) begin
            ex_pc_d          = IdPc;
            ex_mem_wr_data_d = IdMemWrData;
            ex_dst_addr_d    = IdDstAddr;
            ex_out_d         = AluOut;

            if (Flush) begin
                ex_en_d       = 1'b0;
                ex_mem_op_d   = MEM_NOP;
                ex_gpr_we_d   = 1'b0;
                ex_exp_code_d = NO_EXP;
            end else begin
                ex_en_d       = IdEn;
                ex_exp_code_d = exp_code_nxt;
                // An excepting instruction must not commit, but stays valid so EPC is reported.
                if (!IdEn || (exp_code_nxt != NO_EXP)) begin
                    ex_mem_op_d = MEM_NOP;
                    ex_gpr_we_d = 1'b0;
                end else begin
                    ex_mem_op_d = IdMemOp;
                    ex_gpr_we_d = IdGprWe;
                end
                if ((exp_code_nxt == EXP_OVERFLOW) && !(&of_count_q))
                    of_count_d = of_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_) begin
            ex_pc_q          <= '0;
            ex_en_q          <= 1'b0;
            ex_mem_op_q      <= MEM_NOP;
            ex_mem_wr_data_q <= '0;
            ex_dst_addr_q    <= '0;
            ex_gpr_we_q      <= 1'b0;
            ex_exp_code_q    <= NO_EXP;
            ex_out_q         <= '0;
            of_count_q       <= '0;
        end else begin
            ex_pc_q          <= ex_pc_d;
            ex_en_q          <= ex_en_d;
            ex_mem_op_q      <= ex_mem_op_d;
            ex_mem_wr_data_q <= ex_mem_wr_data_d;
            ex_dst_addr_q    <= ex_dst_addr_d;
            ex_gpr_we_q      <= ex_gpr_we_d;
            ex_exp_code_q    <= ex_exp_code_d;
            ex_out_q         <= ex_out_d;
            of_count_q       <= of_count_d;
        end
    end

    assign ExPc        = ex_pc_q;
    assign ExEn        = ex_en_q;
    assign ExMemOp     = ex_mem_op_q;
    assign ExMemWrData = ex_mem_wr_data_q;
    assign ExDstAddr   = ex_dst_addr_q;
    assign ExGprWe     = ex_gpr_we_q;
    assign ExExpCode   = ex_exp_code_q;
    assign ExOut       = ex_out_q;
    assign OfCount     = of_count_q;

endmodule
